// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Start/busy/done handshake; diff and borrow_out hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Counter reaches WIDTH on the final edge, so one extra bit beyond clog2.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             a0, b0, d_bit, br_nxt;
    logic [WIDTH-1:0] res_shift;

    // Next-state, datapath and full-subtractor cell for the current bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        res_d     = res_q;
        br_d      = br_q;
        diff_d    = diff_q;
        bout_d    = bout_q;

        a0        = a_sr_q[0];
        b0        = b_sr_q[0];
        d_bit     = a0 ^ b0 ^ br_q;
        br_nxt    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        // New bit enters at the MSB so after WIDTH shifts the LSB lands at [0].
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = d_bit;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = res_shift;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = res_shift;
                    bout_d  = br_nxt;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule
